// File: rtl/mul_acc_stream.sv
// Streaming multiply-accumulate dot-product engine: LANES products per beat,
// summed by an adder tree and accumulated over BEATS beats into one result.
module mul_acc_stream #(
  parameter int    WIDTH0 = 8,
  parameter int    WIDTH1 = 8,
  parameter int    LANES  = 4,
  parameter int    BEATS  = 2,
  parameter string SIGNED = "yes",
  parameter int    ACCW   = WIDTH0 + WIDTH1 + $clog2(LANES * BEATS)
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iValid_AS0,
  output logic                     oReady_AS0,
  input  logic [LANES*WIDTH0-1:0]  iData_AS0,
  input  logic                     iValid_AS1,
  output logic                     oReady_AS1,
  input  logic [LANES*WIDTH1-1:0]  iData_AS1,
  output logic                     oValid_BM,
  input  logic                     iReady_BM,
  output logic [ACCW-1:0]          oData_BM
);

  localparam bit SGN = (SIGNED == "yes");
  localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  function automatic logic signed [ACCW-1:0] ext0(input logic [WIDTH0-1:0] v);
    if (SGN) return ACCW'($signed(v));
    else     return ACCW'(v);
  endfunction

  function automatic logic signed [ACCW-1:0] ext1(input logic [WIDTH1-1:0] v);
    if (SGN) return ACCW'($signed(v));
    else     return ACCW'(v);
  endfunction

  logic [CW-1:0]           cnt;
  logic                    vld_p0;
  logic                    last_p0;
  logic signed [ACCW-1:0]  prod_p0 [LANES];
  logic signed [ACCW-1:0]  acc;
  logic                    first;
  logic signed [ACCW-1:0]  o_data;
  logic                    o_vld;

  logic                    rdy;
  logic                    fire;
  logic                    acc_adv;
  logic                    is_last_beat;
  logic signed [ACCW-1:0]  tree;
  logic signed [ACCW-1:0]  sum;

  // A stalled last beat only blocks when the held result is not being taken.
  assign acc_adv      = vld_p0 && (!last_p0 || !o_vld || iReady_BM);
  assign rdy          = !vld_p0 || acc_adv;
  assign fire         = iValid_AS0 && iValid_AS1 && rdy;
  assign is_last_beat = (cnt == CW'(BEATS - 1));

  assign oReady_AS0 = rdy;
  assign oReady_AS1 = rdy;
  assign oValid_BM  = o_vld;
  assign oData_BM   = o_data;

  // Stage P: lane-wise products; data path carries no reset.
  always_ff @(posedge iCLK) begin
    if (fire) begin
      for (int i = 0; i < LANES; i++) begin
        prod_p0[i] <= ext0(iData_AS0[i*WIDTH0 +: WIDTH0]) * ext1(iData_AS1[i*WIDTH1 +: WIDTH1]);
      end
    end
  end

  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) begin
      tree = tree + prod_p0[i];
    end
    sum = (first ? ACCW'(0) : acc) + tree;
  end

  // Stage A: accumulate and publish on the last beat.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt     <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      acc     <= '0;
      first   <= 1'b1;
      o_data  <= '0;
      o_vld   <= 1'b0;
    end else begin
      if (fire) begin
        vld_p0  <= 1'b1;
        last_p0 <= is_last_beat;
        cnt     <= is_last_beat ? '0 : cnt + 1'b1;
      end else if (acc_adv) begin
        vld_p0  <= 1'b0;
      end

      if (acc_adv) begin
        if (last_p0) begin
          o_data <= sum;
          first  <= 1'b1;
        end else begin
          acc    <= sum;
          first  <= 1'b0;
        end
      end

      if (acc_adv && last_p0)       o_vld <= 1'b1;
      else if (o_vld && iReady_BM)  o_vld <= 1'b0;
    end
  end

endmodule
